spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, sys_clk cycles allowed between command frame end and data frame start.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'h5A, idle/acknowledge byte presented to the SPI slave for transmission.
REQ-003 SHALL have port sys_clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port nCS  in  1  raw SPI chip select, shared with the SPI slave; asynchronous to sys_clk.
REQ-006 SHALL have port RECV_DATA  in  8  last byte received by the SPI slave.
REQ-007 SHALL have port SEND_DATA  out  8  byte for the SPI slave to transmit in the next frame.
REQ-008 SHALL have port status_in  in  8  read-only status, visible at address 7.
REQ-009 SHALL have port reg_out  out  56  registers 0..6 packed, reg N at bits [8N+7:8N].
REQ-010 SHALL have port wr_pulse  out  1  one-cycle strobe on a completed register write.
REQ-011 SHALL have port wr_addr  out  3  address of the write flagged by wr_pulse.
REQ-012 SHALL have port err_pulse  out  1  one-cycle strobe on protocol error or timeout.

Function
REQ-013 SHALL synchronise nCS through two flops plus one edge-history flop; frame_end = synchronised nCS 0->1, frame_start = 1->0.
REQ-014 SHALL sample RECV_DATA on the cycle after frame_end (sample cycle), not at frame_end itself.
REQ-015 Transaction protocol SHALL be two nCS frames: command frame {rw, addr[6:0]} (rw=1 read, 0 write), then data frame.
REQ-016 SHALL implement states IDLE, WAIT_DATA, DATA_FRAME.
REQ-017 IDLE: on sample cycle latch command, go WAIT_DATA, clear timeout counter.
REQ-018 WAIT_DATA: frame_start -> DATA_FRAME; counter reaching TIMEOUT_CYCLES-1 -> IDLE with err_pulse.
REQ-019 DATA_FRAME: on sample cycle execute command, return IDLE; timeout counter frozen while in DATA_FRAME.
REQ-020 Write, addr 0..6: reg[addr] <= sampled byte; wr_pulse=1 and wr_addr=addr in the cycle after the sample cycle.
REQ-021 Write to addr 7 or addr[6:3]!=0: no register change, no wr_pulse, err_pulse in the cycle after the sample cycle.
REQ-022 Read command: SEND_DATA SHALL be loaded in the cycle after command sample: reg[addr] for 0..6, status_in for 7, 8'hEE for addr[6:3]!=0 (err_pulse also asserted).
REQ-023 Read of addr 7 SHALL capture status_in once, at command sample time + 1; later changes SHALL not alter SEND_DATA during the data frame.
REQ-024 Write command: SEND_DATA SHALL be {1'b0, addr[6:0]} during the data frame (address echo).
REQ-025 SEND_DATA SHALL return to SYNC_BYTE on entry to IDLE.
REQ-026 SEND_DATA SHALL change only while synchronised nCS is high.
REQ-027 Timeout counter SHALL be sized $clog2(TIMEOUT_CYCLES)+1 bits and SHALL saturate, never wrap.
REQ-028 frame_end while in WAIT_DATA (stray edge) is impossible by construction; a frame_start in IDLE has no effect.
REQ-029 wr_pulse and err_pulse SHALL never assert in the same cycle and SHALL each be exactly one cycle wide.

Reset
REQ-030 On rst_n low, state SHALL be IDLE asynchronously.
REQ-031 On rst_n low, SEND_DATA=SYNC_BYTE, reg_out=0, wr_pulse=0, wr_addr=0, err_pulse=0, counter=0.
REQ-032 On rst_n low, synchroniser flops SHALL be set to 1 (nCS inactive), so no frame_end fires after reset release.
REQ-033 Reset mid-transaction SHALL abandon it; the next frame after release is treated as a command frame.

Verification
REQ-034 Write 0x03 then 0xC4 -> reg_out[31:24]=0xC4, wr_pulse one cycle, wr_addr=3, SEND_DATA 0x03 during frame 2, then 0x5A.
REQ-035 Read 0x83 after REQ-034 -> SEND_DATA=0xC4 before frame 2 start, held through frame 2, 0x5A after.
REQ-036 Read 0x87 with status_in=0x3C, changed to 0xFF mid-frame -> SEND_DATA stays 0x3C.
REQ-037 Write 0x07 then 0x11, and read 0x90 -> err_pulse each, reg_out unchanged, read returns 0xEE.
REQ-038 TIMEOUT_CYCLES=16, command 0x02 then no frame for 20 cycles -> err_pulse at cycle 16, IDLE; next frame decoded as command.
REQ-039 rst_n pulsed during data frame of write 0x01 -> reg_out=0, no wr_pulse, SEND_DATA=0x5A.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Register file behind an SPI slave: a command frame {rw, addr} followed by a
// data frame, with SEND_DATA staged for the slave and a command-to-data timeout.
module spi_reg_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = 8'h5A
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        nCS,
  input  logic [7:0]  RECV_DATA,
  output logic [7:0]  SEND_DATA,
  input  logic [7:0]  status_in,
  output logic [55:0] reg_out,
  output logic        wr_pulse,
  output logic [2:0]  wr_addr,
  output logic        err_pulse
);

  localparam int unsigned NUM_REGS = 7;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       STATUS_ADDR = 3'd7;
  localparam logic [7:0]       BAD_ADDR_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DATA  = 2'd1,
    DATA_FRAME = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ncs_meta_q, ncs_sync_q, ncs_hist_q;
  logic             sample_q;
  logic [7:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       send_q, send_d;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       regs_d [NUM_REGS];
  logic             wr_pulse_q, wr_pulse_d;
  logic [2:0]       wr_addr_q, wr_addr_d;
  logic             err_pulse_q, err_pulse_d;
  logic             frame_end_c, frame_start_c;

  // Edge detection on the synchronised chip select.
  assign frame_end_c   = ncs_sync_q & ~ncs_hist_q;
  assign frame_start_c = ~ncs_sync_q & ncs_hist_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    send_d      = send_q;
    regs_d      = regs_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_q) begin
          cmd_d   = RECV_DATA;
          cnt_d   = '0;
          state_d = WAIT_DATA;
          if (!RECV_DATA[7]) begin
            send_d = {1'b0, RECV_DATA[6:0]};
          end else if (RECV_DATA[6:3] != 4'd0) begin
            send_d      = BAD_ADDR_BYTE;
            err_pulse_d = 1'b1;
          end else if (RECV_DATA[2:0] == STATUS_ADDR) begin
            send_d = status_in;
          end else begin
            send_d = regs_q[RECV_DATA[2:0]];
          end
        end
      end

      WAIT_DATA: begin
        if (frame_start_c) begin
          state_d = DATA_FRAME;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          send_d      = SYNC_BYTE;
          err_pulse_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA_FRAME: begin
        if (sample_q) begin
          state_d = IDLE;
          send_d  = SYNC_BYTE;
          if (!cmd_q[7]) begin
            if (cmd_q[6:3] == 4'd0 && cmd_q[2:0] != STATUS_ADDR) begin
              regs_d[cmd_q[2:0]] = RECV_DATA;
              wr_pulse_d         = 1'b1;
              wr_addr_d          = cmd_q[2:0];
            end else begin
              err_pulse_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        send_d  = SYNC_BYTE;
      end
    endcase

    // The slave shifts SEND_DATA out while selected; never disturb it mid-frame.
    if (!ncs_sync_q) begin
      send_d = send_q;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ncs_meta_q  <= 1'b1;
      ncs_sync_q  <= 1'b1;
      ncs_hist_q  <= 1'b1;
      sample_q    <= 1'b0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      send_q      <= SYNC_BYTE;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ncs_meta_q  <= nCS;
      ncs_sync_q  <= ncs_meta_q;
      ncs_hist_q  <= ncs_sync_q;
      sample_q    <= frame_end_c;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      send_q      <= send_d;
      regs_q      <= regs_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[8*g +: 8] = regs_q[g];
  end

  assign SEND_DATA = send_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: stimulus pushes expected strobes into a
// queue that a negedge monitor drains; static values are checked inline.
module tb_spi_reg_ctrl;

  logic        sys_clk;
  logic        rst_n;
  logic        nCS;
  logic [7:0]  RECV_DATA;
  logic [7:0]  SEND_DATA;
  logic [7:0]  status_in;
  logic [55:0] reg_out;
  logic        wr_pulse;
  logic [2:0]  wr_addr;
  logic        err_pulse;

  spi_reg_ctrl #(
    .TIMEOUT_CYCLES(16),
    .SYNC_BYTE     (8'h5A)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .nCS      (nCS),
    .RECV_DATA(RECV_DATA),
    .SEND_DATA(SEND_DATA),
    .status_in(status_in),
    .reg_out  (reg_out),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .err_pulse(err_pulse)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         kind;   // 1 = write strobe, 2 = error strobe
    logic [2:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [55:0] exp_regs = '0;
  logic        wr_prev  = 1'b0;
  logic        err_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = 1; e.addr = a; e.data = d;
    exp_q.push_back(e);
    exp_regs[8*a +: 8] = d;
  endtask

  task automatic push_err();
    ev_t e;
    e.kind = 2; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      wr_prev  = 1'b0;
      err_prev = 1'b0;
    end else begin
      if (wr_pulse && err_pulse) begin
        n_tests++; n_fail++;
        $display("FAIL pulse_overlap: got wr=%b err=%b expected not both", wr_pulse, err_pulse);
      end
      if ((wr_pulse && wr_prev) || (err_pulse && err_prev)) begin
        n_tests++; n_fail++;
        $display("FAIL pulse_width: got wr=%b err=%b held a second cycle expected one cycle", wr_pulse, err_pulse);
      end
      if (wr_pulse || err_pulse) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pulse: got wr=%b err=%b expected none", wr_pulse, err_pulse);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("pulse_kind", {62'd0, err_pulse, wr_pulse}, (e.kind == 1) ? 64'd1 : 64'd2);
          if (e.kind == 1 && wr_pulse) begin
            check("wr_addr", 64'(wr_addr), 64'(e.addr));
            check("wr_data", 64'(reg_out[8*wr_addr +: 8]), 64'(e.data));
          end
        end
      end
      wr_prev  = wr_pulse;
      err_prev = err_pulse;
    end
  end

  task automatic frame_begin(input logic [7:0] rx);
    nCS = 1'b0;
    repeat (4) @(negedge sys_clk);
    RECV_DATA = rx;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic frame_end();
    nCS = 1'b1;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic frame(input logic [7:0] rx);
    frame_begin(rx);
    frame_end();
  endtask

  initial begin
    rst_n     = 1'b0;
    nCS       = 1'b1;
    RECV_DATA = 8'h00;
    status_in = 8'h00;
    repeat (3) @(negedge sys_clk);

    // Reset values
    check("rst_send", 64'(SEND_DATA), 64'h5A);
    check("rst_regs", 64'(reg_out), 64'h0);
    check("rst_wr_pulse", 64'(wr_pulse), 64'h0);
    check("rst_wr_addr", 64'(wr_addr), 64'h0);
    check("rst_err", 64'(err_pulse), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("post_rst_send", 64'(SEND_DATA), 64'h5A);

    // Write 0xC4 to reg 3, with address echo during the data frame
    frame(8'h03);
    check("wr_echo_before", 64'(SEND_DATA), 64'h03);
    frame_begin(8'hC4);
    check("wr_echo_during", 64'(SEND_DATA), 64'h03);
    push_wr(3'd3, 8'hC4);
    frame_end();
    check("wr_idle_send", 64'(SEND_DATA), 64'h5A);
    check("wr_reg_out", 64'(reg_out), 64'(exp_regs));

    // Read reg 3
    frame(8'h83);
    check("rd3_before", 64'(SEND_DATA), 64'hC4);
    frame_begin(8'h00);
    check("rd3_during", 64'(SEND_DATA), 64'hC4);
    frame_end();
    check("rd3_after", 64'(SEND_DATA), 64'h5A);

    // Status read is captured once
    status_in = 8'h3C;
    frame(8'h87);
    status_in = 8'hFF;
    check("status_before", 64'(SEND_DATA), 64'h3C);
    frame_begin(8'h00);
    check("status_during", 64'(SEND_DATA), 64'h3C);
    frame_end();
    check("status_after", 64'(SEND_DATA), 64'h5A);

    // Illegal writes and out-of-range read
    frame(8'h07);
    frame_begin(8'h11);
    push_err();
    frame_end();
    check("wr7_regs", 64'(reg_out), 64'(exp_regs));
    frame(8'h15);
    frame_begin(8'h22);
    push_err();
    frame_end();
    check("wr_hi_regs", 64'(reg_out), 64'(exp_regs));
    frame_begin(8'h90);
    push_err();
    frame_end();
    check("rd_bad_send", 64'(SEND_DATA), 64'hEE);
    frame(8'h00);
    check("rd_bad_after", 64'(SEND_DATA), 64'h5A);
    check("rd_bad_regs", 64'(reg_out), 64'(exp_regs));

    // Boundary registers 0 and 6
    frame(8'h06);
    frame_begin(8'hA5);
    push_wr(3'd6, 8'hA5);
    frame_end();
    frame(8'h00);
    frame_begin(8'h3F);
    push_wr(3'd0, 8'h3F);
    frame_end();
    check("edge_regs", 64'(reg_out), 64'(exp_regs));
    frame(8'h86);
    check("rd6", 64'(SEND_DATA), 64'hA5);
    frame(8'h00);

    // Timeout after command, then next frame is a command
    frame(8'h02);
    push_err();
    repeat (20) @(negedge sys_clk);
    check("timeout_send", 64'(SEND_DATA), 64'h5A);
    frame(8'h83);
    check("post_timeout_cmd", 64'(SEND_DATA), 64'hC4);
    frame(8'h00);
    check("post_timeout_regs", 64'(reg_out), 64'(exp_regs));

    // Reset during the data frame of a write to reg 1
    frame(8'h01);
    frame_begin(8'h77);
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    nCS = 1'b1;
    repeat (3) @(negedge sys_clk);
    exp_regs = '0;
    check("midrst_regs", 64'(reg_out), 64'h0);
    check("midrst_send", 64'(SEND_DATA), 64'h5A);
    rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    check("midrst_regs_after", 64'(reg_out), 64'h0);
    frame(8'h02);
    check("midrst_cmd_echo", 64'(SEND_DATA), 64'h02);
    frame_begin(8'h99);
    push_wr(3'd2, 8'h99);
    frame_end();
    check("midrst_new_write", 64'(reg_out), 64'(exp_regs));

    repeat (10) @(negedge sys_clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

endmodule
